// File: rtl/button_event_ctrl.sv
// Debounces N_BTN push-buttons, classifies each press as short or long, and
// serialises the resulting events over one valid/ready channel with round-robin fairness.
module button_event_ctrl #(
  parameter int N_BTN        = 4,
  parameter int DEBOUNCE_CYC = 1000000,
  parameter int LONG_CYC     = 50000000,
  parameter int CNT_W        = 26,
  parameter int ID_W         = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_BTN-1:0] btn_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [ID_W-1:0]  evt_id,
  output logic             evt_long,
  output logic [N_BTN-1:0] ovf
);

  typedef enum logic [1:0] {
    S_IDLE      = 2'd0,
    S_DEBOUNCE  = 2'd1,
    S_PRESSED   = 2'd2,
    S_LONG_HELD = 2'd3
  } state_e;

  localparam logic [CNT_W-1:0] DEB_CNT  = CNT_W'(DEBOUNCE_CYC);
  localparam logic [CNT_W-1:0] LONG_CNT = CNT_W'(LONG_CYC);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (c >= LONG_CNT) ? LONG_CNT : c + CNT_W'(1);
  endfunction

  logic [N_BTN-1:0] sync1_q, sync1_d;
  logic [N_BTN-1:0] sync2_q, sync2_d;
  logic [N_BTN-1:0] btn_s;

  state_e           state_q [N_BTN];
  state_e           state_d [N_BTN];
  logic [CNT_W-1:0] cnt_q   [N_BTN];
  logic [CNT_W-1:0] cnt_d   [N_BTN];

  logic [N_BTN-1:0] gen_evt;
  logic [N_BTN-1:0] gen_long;

  logic [N_BTN-1:0] slot_occ_q, slot_occ_d;
  logic [N_BTN-1:0] slot_long_q, slot_long_d;
  logic [N_BTN-1:0] ovf_q, ovf_d;

  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic             evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]  evt_id_q, evt_id_d;
  logic             evt_long_q, evt_long_d;

  logic             load_en;
  logic             found;
  logic [ID_W-1:0]  gnt_idx;
  logic             gnt_long;
  logic [N_BTN-1:0] gnt_vec;

  // Two-flop synchronizer for the asynchronous button levels
  always_comb begin
    sync1_d = btn_in;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  assign btn_s = sync2_q;

  // Per-button FSM: state register
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_BTN; i++) begin
      if (rst) begin
        state_q[i] <= S_IDLE;
        cnt_q[i]   <= '0;
      end else begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
    end
  end

  // Per-button FSM: next state and hold counter
  always_comb begin
    for (int i = 0; i < N_BTN; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
      case (state_q[i])
        S_IDLE: begin
          if (btn_s[i]) begin
            state_d[i] = S_DEBOUNCE;
            cnt_d[i]   = CNT_W'(1);
          end
        end
        S_DEBOUNCE: begin
          if (!btn_s[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else begin
            if (cnt_q[i] == DEB_CNT) begin
              state_d[i] = S_PRESSED;
            end
            cnt_d[i] = sat_inc(cnt_q[i]);
          end
        end
        S_PRESSED: begin
          if (!btn_s[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end else if (cnt_q[i] == LONG_CNT) begin
            state_d[i] = S_LONG_HELD;
          end else begin
            cnt_d[i] = sat_inc(cnt_q[i]);
          end
        end
        S_LONG_HELD: begin
          if (!btn_s[i]) begin
            state_d[i] = S_IDLE;
            cnt_d[i]   = '0;
          end
        end
        default: begin
          state_d[i] = S_IDLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  // Per-button FSM: event outputs (release from PRESSED is short, reaching LONG_CNT is long)
  always_comb begin
    gen_evt  = '0;
    gen_long = '0;
    for (int i = 0; i < N_BTN; i++) begin
      if (state_q[i] == S_PRESSED) begin
        if (!btn_s[i]) begin
          gen_evt[i] = 1'b1;
        end else if (cnt_q[i] == LONG_CNT) begin
          gen_evt[i]  = 1'b1;
          gen_long[i] = 1'b1;
        end
      end
    end
  end

  // Round-robin search: first occupied slot at or above rr_ptr, then wrap to the bottom
  always_comb begin
    load_en  = !evt_valid_q || evt_ready;
    found    = 1'b0;
    gnt_idx  = '0;
    gnt_long = 1'b0;
    for (int i = 0; i < N_BTN; i++) begin
      if (!found && slot_occ_q[i] && (i >= int'(rr_ptr_q))) begin
        found    = 1'b1;
        gnt_idx  = ID_W'(i);
        gnt_long = slot_long_q[i];
      end
    end
    for (int i = 0; i < N_BTN; i++) begin
      if (!found && slot_occ_q[i]) begin
        found    = 1'b1;
        gnt_idx  = ID_W'(i);
        gnt_long = slot_long_q[i];
      end
    end
    gnt_vec = '0;
    for (int i = 0; i < N_BTN; i++) begin
      gnt_vec[i] = load_en && found && (int'(gnt_idx) == i);
    end
  end

  // Pending slots: a grant frees the slot in time for a same-cycle new event
  always_comb begin
    slot_occ_d  = slot_occ_q;
    slot_long_d = slot_long_q;
    ovf_d       = ovf_q;
    for (int i = 0; i < N_BTN; i++) begin
      if (gen_evt[i]) begin
        if (slot_occ_q[i] && !gnt_vec[i]) begin
          ovf_d[i] = 1'b1;
        end else begin
          slot_occ_d[i]  = 1'b1;
          slot_long_d[i] = gen_long[i];
        end
      end else if (gnt_vec[i]) begin
        slot_occ_d[i] = 1'b0;
      end
    end
  end

  // Output register and pointer update
  always_comb begin
    evt_valid_d = evt_valid_q;
    evt_id_d    = evt_id_q;
    evt_long_d  = evt_long_q;
    rr_ptr_d    = rr_ptr_q;
    if (load_en) begin
      if (found) begin
        evt_valid_d = 1'b1;
        evt_id_d    = gnt_idx;
        evt_long_d  = gnt_long;
        rr_ptr_d    = (int'(gnt_idx) == N_BTN - 1) ? '0 : gnt_idx + ID_W'(1);
      end else begin
        evt_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      slot_occ_q  <= '0;
      slot_long_q <= '0;
      ovf_q       <= '0;
      rr_ptr_q    <= '0;
      evt_valid_q <= 1'b0;
      evt_id_q    <= '0;
      evt_long_q  <= 1'b0;
    end else begin
      slot_occ_q  <= slot_occ_d;
      slot_long_q <= slot_long_d;
      ovf_q       <= ovf_d;
      rr_ptr_q    <= rr_ptr_d;
      evt_valid_q <= evt_valid_d;
      evt_id_q    <= evt_id_d;
      evt_long_q  <= evt_long_d;
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_long  = evt_long_q;
  assign ovf       = ovf_q;

endmodule
